ft2232h_sync_tx_fifo: RTL

FT2232H_SYNC_TX_FIFO -- requirements
Module: ft2232h_sync_tx_fifo

---
 rtl/ft2232h_sync_tx_fifo.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ft2232h_sync_tx_fifo.sv
// ---------------------------------------------------------------------------
// ft2232h_sync_tx_fifo
// Buffers upstream words and streams them byte by byte into an FT2232H in
// synchronous FIFO mode (single 60 MHz CLKOUT domain). Bursts are limited to
// BURST_MAX committed bytes, after which WR# is held high for GAP_CYCLES
// cycles. A flush request produces a one-cycle SIWU# pulse once every
// buffered byte has been committed.
//
// Parameters
//   IN_BYTES   : bytes per upstream word (1..4), W = 8*IN_BYTES
//   DEPTH      : buffered upstream words (power of two, >= 2)
//   BURST_MAX  : committed bytes per burst before a forced gap
//   GAP_CYCLES : cycles WR# stays high after a full burst (>= 1)
//
// Ports
//   clk      in   FT2232H CLKOUT, all logic on rising edge
//   rst      in   synchronous active-high reset
//   s_valid  in   upstream word valid
//   s_ready  out  buffer can accept a word (level < DEPTH)
//   s_data   in   upstream word, byte 0 = s_data[7:0] is sent first
//   flush    in   one-cycle request to send-immediate buffered data
//   txe      in   FT2232H TXE#, active-low
//   wr       out  FT2232H WR#, active-low, registered
//   siwu     out  FT2232H SIWU#, active-low, registered
//   data_out out  byte on the FT2232H data bus, registered
//   level    out  words currently buffered
// ---------------------------------------------------------------------------
module ft2232h_sync_tx_fifo #(
  parameter int IN_BYTES   = 1,
  parameter int DEPTH      = 16,
  parameter int BURST_MAX  = 512,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [8*IN_BYTES-1:0]  s_data,
  input  logic                   flush,
  input  logic                   txe,
  output logic                   wr,
  output logic                   siwu,
  output logic [7:0]             data_out,
  output logic [$clog2(DEPTH):0] level
);

  localparam int W  = 8 * IN_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SEND = 2'b01;
  localparam logic [1:0] GAP  = 2'b10;

  logic [W-1:0]  mem [DEPTH];
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW-1:0] wr_ptr;
  logic [BW-1:0] byte_idx;
  logic [BW-1:0] idx_nxt;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] burst_nxt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_nxt;
  logic [LW-1:0] level_nxt;
  logic          wr_nxt;
  logic [7:0]    dout_nxt;
  logic          flush_pend;
  logic          pend_eff;
  logic          fire;
  logic          push;
  logic          commit;
  logic          last_byte;
  logic          pop;
  logic [7:0]    head_byte;
  logic [7:0]    next_byte;

  // Select byte idx of a buffered word (only indices below IN_BYTES exist).
  function automatic logic [7:0] pick_byte(input logic [W-1:0] word,
                                           input logic [BW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < IN_BYTES; i++) begin
      b = (idx == BW'(i)) ? word[i*8 +: 8] : b;
    end
    return b;
  endfunction

  assign push       = s_valid & s_ready & ~rst;
  assign commit     = (state == SEND) & ~wr & ~txe;
  assign last_byte  = (byte_idx == BW'(IN_BYTES - 1));
  assign pop        = commit & last_byte;
  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign head_byte  = pick_byte(mem[rd_ptr], byte_idx);
  // Byte to present after a commit; crosses into the next word after byte IN_BYTES-1.
  assign next_byte  = last_byte ? pick_byte(mem[rd_ptr_inc], BW'(0))
                                : pick_byte(mem[rd_ptr], byte_idx + BW'(1));

  // Buffered word count after this edge.
  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (!push && pop) begin
      level_nxt = level - LW'(1);
    end else begin
      level_nxt = level;
    end
  end

  // Transmit state machine: next state, WR#, bus byte, read position, counters.
  always_comb begin
    state_nxt = state;
    wr_nxt    = wr;
    dout_nxt  = data_out;
    rd_nxt    = rd_ptr;
    idx_nxt   = byte_idx;
    burst_nxt = burst_cnt;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        burst_nxt = CW'(0);
        if ((level != LW'(0)) && !txe) begin
          state_nxt = SEND;
          wr_nxt    = 1'b0;
          dout_nxt  = head_byte;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (txe) begin
          // Byte on the bus was not taken: keep it and retry from IDLE.
          state_nxt = IDLE;
          wr_nxt    = 1'b1;
          burst_nxt = CW'(0);
        end else if (!wr) begin
          rd_nxt    = last_byte ? rd_ptr_inc : rd_ptr;
          idx_nxt   = last_byte ? BW'(0) : byte_idx + BW'(1);
          burst_nxt = burst_cnt + CW'(1);
          if (burst_cnt == CW'(BURST_MAX - 1)) begin
            state_nxt = GAP;
            wr_nxt    = 1'b1;
            burst_nxt = CW'(0);
            gap_nxt   = GW'(0);
          end else if (pop && (level == LW'(1))) begin
            state_nxt = IDLE;
            wr_nxt    = 1'b1;
            burst_nxt = CW'(0);
          end else begin
            dout_nxt  = next_byte;
          end
        end else begin
          state_nxt = IDLE;
          wr_nxt    = 1'b1;
          burst_nxt = CW'(0);
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          // Gap expiry takes the IDLE decision on the same edge so WR# is
          // high for exactly GAP_CYCLES cycles when data is waiting.
          burst_nxt = CW'(0);
          if ((level != LW'(0)) && !txe) begin
            state_nxt = SEND;
            wr_nxt    = 1'b0;
            dout_nxt  = head_byte;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        wr_nxt    = 1'b1;
        burst_nxt = CW'(0);
      end
    endcase
  end

  // SIWU# fires once the buffer drains with nothing left on the bus; it is
  // never fired back-to-back so every pulse is exactly one cycle wide.
  assign pend_eff = flush_pend | flush;
  assign fire     = pend_eff & siwu & (level_nxt == LW'(0)) & (state_nxt != SEND);

  // Registered state, outputs and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr         <= 1'b1;
      siwu       <= 1'b1;
      data_out   <= 8'h00;
      level      <= LW'(0);
      s_ready    <= 1'b0;
      rd_ptr     <= AW'(0);
      wr_ptr     <= AW'(0);
      byte_idx   <= BW'(0);
      burst_cnt  <= CW'(0);
      gap_cnt    <= GW'(0);
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr         <= wr_nxt;
      siwu       <= ~fire;
      data_out   <= dout_nxt;
      level      <= level_nxt;
      s_ready    <= (level_nxt < LW'(DEPTH));
      rd_ptr     <= rd_nxt;
      wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
      byte_idx   <= idx_nxt;
      burst_cnt  <= burst_nxt;
      gap_cnt    <= gap_nxt;
      flush_pend <= fire ? 1'b0 : pend_eff;
    end
  end

  // Word storage; contents need no reset because pointers and level do.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

endmodule
